scan_writer: RTL and testbench

Write-back address generator for the edge-detection pipeline; the write-side counterpart of the scan-order read counter. Accepts per-pixel edge results arriving in scan order (left-right, up-down, or either diagonal) over a valid/ready handshake. Reconstructs each result's (row, col) position in the WIDTH×WIDTH image and issues one write per result into the result buffer. Flags line ends and frame completion, and checks the upstream line-end marker.

---
 rtl/scan_pkg.sv | 32 +++
 rtl/scan_coord_step.sv | 106 ++++++++++
 rtl/scan_writer.sv | 172 +++++++++++++++++
 tb/tb_scan_writer.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/scan_pkg.sv
// Shared definitions for the scan-order address generators (read counter and write-back).
// Holds the mode and state encodings plus the per-mode first coordinate.
package scan_pkg;

  localparam int DEF_WIDTH  = 150;
  localparam int DEF_PIXELS = DEF_WIDTH * DEF_WIDTH;

  typedef enum logic [1:0] {
    MODE_LR = 2'd0,
    MODE_UD = 2'd1,
    MODE_DL = 2'd2,
    MODE_DR = 2'd3
  } scan_mode_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } scan_state_e;

  // Every order starts in row 0; only the diagonal (DR) order starts at the right edge.
  function automatic int unsigned first_col(input scan_mode_e m, input int unsigned width);
    int unsigned c;
    c = 32'd0;
    case (m)
      MODE_DR: c = width - 32'd1;
      default: c = 32'd0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/scan_coord_step.sv
// Combinational scan-order stepper: given the current (row, col) it returns the next
// coordinate and flags the end of a scan line and the final pixel of the frame.
module scan_coord_step
  import scan_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CW    = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  scan_mode_e      mode_i,
  input  logic [CW-1:0]   row_i,
  input  logic [CW-1:0]   col_i,
  output logic [CW-1:0]   row_o,
  output logic [CW-1:0]   col_o,
  output logic            line_end_o,
  output logic            last_pixel_o
);

  localparam logic [CW-1:0] MAXC   = CW'(WIDTH - 1);
  localparam logic [CW-1:0] ONE    = CW'(1);
  localparam logic [CW:0]   KMAX_W = (CW + 1)'(WIDTH - 1);

  logic          row_max_s;
  logic          col_max_s;
  logic          col_min_s;
  logic [CW:0]   diag_k_s;
  logic [CW:0]   diag_kn_s;

  assign row_max_s = (row_i == MAXC);
  assign col_max_s = (col_i == MAXC);
  assign col_min_s = (col_i == '0);

  // Anti-diagonal index k = row + col and its successor, one bit wider than a coordinate.
  assign diag_k_s  = {1'b0, row_i} + {1'b0, col_i};
  assign diag_kn_s = diag_k_s + (CW + 1)'(1);

  // Per-mode successor coordinate and line/frame end flags.
  always_comb begin
    row_o        = row_i;
    col_o        = col_i;
    line_end_o   = 1'b0;
    last_pixel_o = 1'b0;
    case (mode_i)
      MODE_LR: begin
        line_end_o   = col_max_s;
        last_pixel_o = row_max_s && col_max_s;
        if (col_max_s) begin
          col_o = '0;
          row_o = row_i + ONE;
        end else begin
          col_o = col_i + ONE;
        end
      end
      MODE_UD: begin
        line_end_o   = row_max_s;
        last_pixel_o = row_max_s && col_max_s;
        if (row_max_s) begin
          row_o = '0;
          col_o = col_i + ONE;
        end else begin
          row_o = row_i + ONE;
        end
      end
      MODE_DL: begin
        line_end_o   = row_max_s || col_min_s;
        last_pixel_o = row_max_s && col_max_s;
        if (row_max_s || col_min_s) begin
          // Next line k+1 starts at (max(0, k+1-(W-1)), min(k+1, W-1)).
          if (diag_kn_s > KMAX_W) begin
            row_o = CW'(diag_kn_s - KMAX_W);
            col_o = MAXC;
          end else begin
            row_o = '0;
            col_o = CW'(diag_kn_s);
          end
        end else begin
          row_o = row_i + ONE;
          col_o = col_i - ONE;
        end
      end
      MODE_DR: begin
        line_end_o   = row_max_s || col_max_s;
        last_pixel_o = row_max_s && col_min_s;
        if (row_max_s || col_max_s) begin
          // d = col - row steps down by one: (0, d-1) while d > 0, else (1-d, 0).
          if (col_i > row_i) begin
            row_o = '0;
            col_o = col_i - row_i - ONE;
          end else begin
            row_o = row_i - col_i + ONE;
            col_o = '0;
          end
        end else begin
          row_o = row_i + ONE;
          col_o = col_i + ONE;
        end
      end
      default: begin
        row_o        = row_i;
        col_o        = col_i;
        line_end_o   = 1'b0;
        last_pixel_o = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/scan_writer.sv
// Write-back address generator: turns a scan-ordered stream of edge results into
// result-buffer writes at row*WIDTH+col, flagging line ends, frame completion and marker errors.
module scan_writer
  import scan_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int ADDR_W = 15,
  parameter int DATA_W = 1
) (
  input  logic              clk,
  input  logic              resetIn,
  input  logic [1:0]        mode,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              line_end,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int FW = 2 * CW + 1;

  scan_state_e        state_q,    state_d;
  scan_mode_e         mode_q,     mode_d;
  logic [CW-1:0]      row_q,      row_d;
  logic [CW-1:0]      col_q,      col_d;
  logic               in_ready_q, in_ready_d;
  logic               busy_q,     busy_d;
  logic               wr_en_q,    wr_en_d;
  logic [ADDR_W-1:0]  wr_addr_q,  wr_addr_d;
  logic [DATA_W-1:0]  wr_data_q,  wr_data_d;
  logic               line_end_q, line_end_d;
  logic               done_q,     done_d;
  logic               err_q,      err_d;

  logic [CW-1:0]      step_row_s;
  logic [CW-1:0]      step_col_s;
  logic               step_le_s;
  logic               step_last_s;
  logic               accept_s;
  logic [FW-1:0]      addr_full_s;

  scan_coord_step #(
    .WIDTH (WIDTH),
    .CW    (CW)
  ) u_step (
    .mode_i       (mode_q),
    .row_i        (row_q),
    .col_i        (col_q),
    .row_o        (step_row_s),
    .col_o        (step_col_s),
    .line_end_o   (step_le_s),
    .last_pixel_o (step_last_s)
  );

  // in_ready_q is only ever high in RUN, so it alone qualifies a beat.
  assign accept_s    = in_valid && in_ready_q;
  assign addr_full_s = FW'(row_q) * FW'(WIDTH) + FW'(col_q);

  // Next-state, coordinate advance and write-port decode.
  always_comb begin
    state_d    = state_q;
    mode_d     = mode_q;
    row_d      = row_q;
    col_d      = col_q;
    err_d      = err_q;
    wr_en_d    = 1'b0;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    line_end_d = 1'b0;
    done_d     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          mode_d  = scan_mode_e'(mode);
          row_d   = '0;
          col_d   = CW'(first_col(scan_mode_e'(mode), WIDTH));
          err_d   = 1'b0;
          state_d = ST_RUN;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (accept_s) begin
          wr_en_d    = 1'b1;
          wr_addr_d  = ADDR_W'(addr_full_s);
          wr_data_d  = in_data;
          line_end_d = step_le_s;
          done_d     = step_last_s;
          row_d      = step_row_s;
          col_d      = step_col_s;
          if (in_last != step_le_s) begin
            err_d = 1'b1;
          end else begin
            err_d = err_q;
          end
          if (step_last_s) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_RUN;
          end
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    in_ready_d = (state_d == ST_RUN);
    busy_d     = (state_d != ST_IDLE);
  end

  // FSM state register.
  always_ff @(posedge clk or posedge resetIn) begin
    if (resetIn) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Coordinate, handshake and write-port registers; reset abandons any frame in flight.
  always_ff @(posedge clk or posedge resetIn) begin
    if (resetIn) begin
      mode_q     <= MODE_LR;
      row_q      <= '0;
      col_q      <= '0;
      in_ready_q <= 1'b0;
      busy_q     <= 1'b0;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      line_end_q <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      mode_q     <= mode_d;
      row_q      <= row_d;
      col_q      <= col_d;
      in_ready_q <= in_ready_d;
      busy_q     <= busy_d;
      wr_en_q    <= wr_en_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      line_end_q <= line_end_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  assign in_ready = in_ready_q;
  assign busy     = busy_q;
  assign wr_en    = wr_en_q;
  assign wr_addr  = wr_addr_q;
  assign wr_data  = wr_data_q;
  assign line_end = line_end_q;
  assign done     = done_q;
  assign err      = err_q;

endmodule

// File: tb/tb_scan_writer.sv
// Directed bench for scan_writer at WIDTH=150: full DL/DR frames, partial LR/UD frames
// with handshake gaps, ignored starts, marker errors and mid-frame reset.
module tb_scan_writer;

  localparam int W     = 150;
  localparam int AW    = 15;
  localparam int TOTAL = W * W;

  logic          clk = 1'b0;
  logic          rst;
  logic [1:0]    mode;
  logic          start;
  logic          in_valid;
  logic          in_ready;
  logic [0:0]    in_data;
  logic          in_last;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [0:0]    wr_data;
  logic          line_end;
  logic          busy;
  logic          done;
  logic          err;

  int n_checks = 0;
  int n_errors = 0;
  int exp_addr [TOTAL];
  bit exp_le   [TOTAL];
  int got_addr [TOTAL];
  bit seen     [TOTAL];
  int le_cnt;
  int dup_cnt;
  int seen_cnt;

  scan_writer #(.WIDTH(W), .ADDR_W(AW), .DATA_W(1)) dut (
    .clk      (clk),
    .resetIn  (rst),
    .mode     (mode),
    .start    (start),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .in_last  (in_last),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .line_end (line_end),
    .busy     (busy),
    .done     (done),
    .err      (err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  function automatic logic data_pat(input int i);
    return ((i * 7) % 5) > 2;
  endfunction

  // Reference order built line by line from the scan definitions.
  task automatic build_expected(input int m);
    int n;
    int rs;
    int re;
    n = 0;
    case (m)
      0: for (int r = 0; r < W; r++)
           for (int c = 0; c < W; c++) begin
             exp_addr[n] = r * W + c; exp_le[n] = (c == W - 1); n++;
           end
      1: for (int c = 0; c < W; c++)
           for (int r = 0; r < W; r++) begin
             exp_addr[n] = r * W + c; exp_le[n] = (r == W - 1); n++;
           end
      2: for (int k = 0; k <= 2 * W - 2; k++) begin
           rs = (k > W - 1) ? k - W + 1 : 0;
           re = (k < W - 1) ? k : W - 1;
           for (int r = rs; r <= re; r++) begin
             exp_addr[n] = r * W + (k - r); exp_le[n] = (r == re); n++;
           end
         end
      default: for (int d = W - 1; d >= -(W - 1); d--) begin
           rs = (d >= 0) ? 0 : -d;
           re = (d >= 0) ? W - 1 - d : W - 1;
           for (int r = rs; r <= re; r++) begin
             exp_addr[n] = r * W + (r + d); exp_le[n] = (r == re); n++;
           end
         end
    endcase
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_in_ready"}, in_ready, 0);
    check({tag, "_wr_en"},    wr_en,    0);
    check({tag, "_wr_addr"},  wr_addr,  0);
    check({tag, "_wr_data"},  wr_data,  0);
    check({tag, "_line_end"}, line_end, 0);
    check({tag, "_busy"},     busy,     0);
    check({tag, "_done"},     done,     0);
    check({tag, "_err"},      err,      0);
  endtask

  task automatic run_frame(input logic [1:0] m, input int n_wr, input bit toggle,
                           input int bad_beat, input int pulse_beat);
    int wr;
    int cyc;
    int a;
    bit vld;
    bit exp_err;
    build_expected(int'(m));
    for (int i = 0; i < TOTAL; i++) seen[i] = 1'b0;
    le_cnt = 0; dup_cnt = 0; seen_cnt = 0;
    mode = m; start = 1'b1;
    tick();
    start = 1'b0;
    check("start_in_ready", in_ready, 1);
    check("start_busy", busy, 1);
    check("start_err_clear", err, 0);
    exp_err = 1'b0; wr = 0; cyc = 0;
    while (wr < n_wr && cyc < 4 * n_wr + 100) begin
      vld      = !toggle || ($urandom_range(0, 1) == 1);
      in_valid = vld;
      in_data  = data_pat(wr);
      in_last  = exp_le[wr] ^ (wr == bad_beat);
      start    = (wr == pulse_beat);
      mode     = (wr == pulse_beat) ? (m ^ 2'd1) : m;
      tick();
      check("wr_en", wr_en, vld);
      check("in_ready", in_ready, !(vld && wr == TOTAL - 1));
      if (vld) begin
        if (wr == bad_beat) exp_err = 1'b1;
        check("wr_addr", wr_addr, exp_addr[wr]);
        check("line_end", line_end, exp_le[wr]);
        check("wr_data", wr_data, data_pat(wr));
        check("done", done, (wr == TOTAL - 1));
        got_addr[wr] = int'(wr_addr);
        if (line_end) le_cnt++;
        a = int'(wr_addr);
        if (a < TOTAL && !seen[a]) begin
          seen[a] = 1'b1; seen_cnt++;
        end else begin
          dup_cnt++;
        end
        wr++;
      end else begin
        check("done_no_write", done, 0);
      end
      check("err", err, exp_err);
      cyc++;
    end
    in_valid = 1'b0; start = 1'b0; in_last = 1'b0; mode = m;
    check("frame_writes_within_budget", wr, n_wr);
  endtask

  // DONE lasts one cycle: start and valid offered there are ignored.
  task automatic done_tail();
    check("done_busy", busy, 1);
    check("done_in_ready", in_ready, 0);
    start = 1'b1; in_valid = 1'b1;
    tick();
    start = 1'b0; in_valid = 1'b0;
    check("post_done_busy", busy, 0);
    check("post_done_in_ready", in_ready, 0);
    check("post_done_wr_en", wr_en, 0);
    check("post_done_done", done, 0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = 1'b0; in_last = 1'b0; mode = 2'd0;
    #1;
    check_zero("reset");
    tick();
    tick();
    rst = 1'b0;

    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    check("idle_wr_en", wr_en, 0);
    check("idle_in_ready", in_ready, 0);
    check("idle_busy", busy, 0);

    // DL: full frame, continuous valid
    run_frame(2'd2, TOTAL, 1'b0, -1, -1);
    check("dl_a0", got_addr[0], 0);
    check("dl_a1", got_addr[1], 1);
    check("dl_a2", got_addr[2], 150);
    check("dl_a3", got_addr[3], 2);
    check("dl_a4", got_addr[4], 151);
    check("dl_a5", got_addr[5], 300);
    check("dl_final", got_addr[TOTAL - 1], 22499);
    check("dl_lines", le_cnt, 299);
    check("dl_coverage", seen_cnt, TOTAL);
    check("dl_dups", dup_cnt, 0);
    done_tail();

    // DR: full frame, wrong in_last on beat 5
    run_frame(2'd3, TOTAL, 1'b0, 5, -1);
    check("dr_a0", got_addr[0], 149);
    check("dr_a1", got_addr[1], 148);
    check("dr_a2", got_addr[2], 299);
    check("dr_a3", got_addr[3], 147);
    check("dr_a4", got_addr[4], 298);
    check("dr_a5", got_addr[5], 449);
    check("dr_final", got_addr[TOTAL - 1], 22350);
    check("dr_lines", le_cnt, 299);
    check("dr_coverage", seen_cnt, TOTAL);
    check("dr_dups", dup_cnt, 0);
    done_tail();
    check("err_sticky_in_idle", err, 1);

    // LR: gappy valid, ignored mid-frame start, bad marker, then reset after 1000 writes
    run_frame(2'd0, 1000, 1'b1, 5, 100);
    check("lr_a149", got_addr[149], 149);
    check("lr_a150", got_addr[150], 150);
    check("lr_a999", got_addr[999], 999);
    check("lr_lines", le_cnt, 6);
    rst = 1'b1;
    #1;
    check_zero("midframe_reset");
    tick();
    rst = 1'b0;

    // LR restarts from address 0 after the abandoned frame
    run_frame(2'd0, 200, 1'b0, -1, -1);
    check("lr2_a0", got_addr[0], 0);
    check("lr2_a149", got_addr[149], 149);
    check("lr2_a150", got_addr[150], 150);
    check("lr2_lines", le_cnt, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;

    // UD: first two columns
    run_frame(2'd1, 300, 1'b0, -1, -1);
    check("ud_a1", got_addr[1], 150);
    check("ud_a149", got_addr[149], 22350);
    check("ud_a150", got_addr[150], 1);
    check("ud_a151", got_addr[151], 151);
    check("ud_a299", got_addr[299], 22351);
    check("ud_lines", le_cnt, 2);
    rst = 1'b1;
    tick();
    rst = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
